// File: rtl/qam16_rx_frame_ctrl.sv
// QAM16 receive frame sequencer: hunts for a sync word, reads a 16-bit length header,
// then emits that many 32-bit payload words with sop/eop framing and status pulses.
module qam16_rx_frame_ctrl #(
    parameter logic [31:0] SYNC_WORD = 32'hA5F03C96,
    parameter int unsigned MAX_LEN   = 1024,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic        valid_i,
    input  logic [3:0]  sym_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic        frame_done,
    output logic        abort,
    output logic        len_err,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] HEADER  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned FILL_W = 4;
    localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  IDLE_LAST = LEN_W'(TIMEOUT - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(8);

    logic [1:0]        state, state_d;
    logic [31:0]       shreg, shreg_d, shifted;
    logic [FILL_W-1:0] fill, fill_d;
    logic [LEN_W-1:0]  idle, idle_d;
    logic [LEN_W-1:0]  len, len_d;
    logic [LEN_W-1:0]  wcnt, wcnt_d;
    logic [2:0]        ncnt, ncnt_d;
    logic [31:0]       data_d;
    logic [15:0]       cnt_d;
    logic              valid_d, sop_d, eop_d, done_d, abort_d, len_err_d, busy_d;

    assign shifted = {shreg[27:0], sym_i};

    // State register and all registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= HUNT;
            shreg      <= '0;
            fill       <= '0;
            idle       <= '0;
            len        <= '0;
            wcnt       <= '0;
            ncnt       <= '0;
            valid_o    <= 1'b0;
            data_o     <= '0;
            sop_o      <= 1'b0;
            eop_o      <= 1'b0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
            len_err    <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            fill       <= fill_d;
            idle       <= idle_d;
            len        <= len_d;
            wcnt       <= wcnt_d;
            ncnt       <= ncnt_d;
            valid_o    <= valid_d;
            data_o     <= data_d;
            sop_o      <= sop_d;
            eop_o      <= eop_d;
            frame_done <= done_d;
            abort      <= abort_d;
            len_err    <= len_err_d;
            busy       <= busy_d;
            frame_cnt  <= cnt_d;
        end
    end

    // Next-state and output decode; every return to HUNT wipes the hunt history
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        fill_d    = fill;
        idle_d    = idle;
        len_d     = len;
        wcnt_d    = wcnt;
        ncnt_d    = ncnt;
        data_d    = data_o;
        cnt_d     = frame_cnt;
        valid_d   = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        len_err_d = 1'b0;

        if (!en) begin
            abort_d = (state != HUNT);
            state_d = HUNT;
            shreg_d = '0;
            fill_d  = '0;
            idle_d  = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (valid_i) begin
                        shreg_d = shifted;
                        fill_d  = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
                        if (shifted == SYNC_WORD && fill_d == FILL_FULL) begin
                            state_d = HEADER;
                            ncnt_d  = '0;
                            idle_d  = '0;
                        end
                    end
                end
                HEADER, PAYLOAD: begin
                    if (valid_i) begin
                        idle_d  = '0;
                        shreg_d = shifted;
                        ncnt_d  = ncnt + 3'd1;
                        if (state == HEADER && ncnt == 3'd3) begin
                            if (shifted[15:0] == '0 || shifted[15:0] > MAX_LEN_V) begin
                                len_err_d = 1'b1;
                                state_d   = HUNT;
                                shreg_d   = '0;
                                fill_d    = '0;
                            end else begin
                                len_d   = shifted[15:0];
                                wcnt_d  = '0;
                                ncnt_d  = '0;
                                state_d = PAYLOAD;
                            end
                        end else if (state == PAYLOAD && ncnt == 3'd7) begin
                            valid_d = 1'b1;
                            data_d  = shifted;
                            sop_d   = (wcnt == '0);
                            eop_d   = (wcnt == len - LEN_W'(1));
                            wcnt_d  = wcnt + LEN_W'(1);
                            if (eop_d) begin
                                done_d  = 1'b1;
                                cnt_d   = frame_cnt + 16'd1;
                                state_d = HUNT;
                                shreg_d = '0;
                                fill_d  = '0;
                            end
                        end
                    end else if (idle == IDLE_LAST) begin
                        abort_d = 1'b1;
                        state_d = HUNT;
                        shreg_d = '0;
                        fill_d  = '0;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle + LEN_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    shreg_d = '0;
                    fill_d  = '0;
                    idle_d  = '0;
                end
            endcase
        end

        busy_d = (state_d != HUNT);
    end

endmodule

// File: tb/tb_qam16_rx_frame_ctrl.sv
// Self-checking bench for qam16_rx_frame_ctrl: payload words are checked against
// a scoreboard queue, status pulses against per-scenario expected counts.
module tb_qam16_rx_frame_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en;
    logic        valid_i;
    logic [3:0]  sym_i;
    logic        valid_o;
    logic [31:0] data_o;
    logic        sop_o;
    logic        eop_o;
    logic        frame_done;
    logic        abort;
    logic        len_err;
    logic        busy;
    logic [15:0] frame_cnt;

    qam16_rx_frame_ctrl dut (
        .CLK(CLK), .RST(RST), .en(en), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(valid_o), .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o),
        .frame_done(frame_done), .abort(abort), .len_err(len_err),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t q[$];
    int tests_run = 0;
    int tests_failed = 0;
    int n_valid = 0, n_abort = 0, n_len_err = 0, n_done = 0;
    logic [31:0] sync_v = 32'hA5F03C96;

    // Output monitor: scoreboard pop on every payload word, framing rules every cycle
    always @(negedge CLK) begin
        if (!RST) begin
            if (valid_o) begin
                n_valid++;
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_word: data_o=%h sop=%b eop=%b, required no word", data_o, sop_o, eop_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({data_o, sop_o, eop_o, frame_done} !== {e.d, e.sop, e.eop, e.eop}) begin
                        tests_failed++;
                        $display("FAIL word: data/sop/eop/done=%h/%b/%b/%b, required %h/%b/%b/%b",
                                 data_o, sop_o, eop_o, frame_done, e.d, e.sop, e.eop, e.eop);
                    end
                end
            end else begin
                tests_run++;
                if ({sop_o, eop_o, frame_done} !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL idle_flags: sop/eop/done=%b%b%b with valid_o=0, required 000", sop_o, eop_o, frame_done);
                end
            end
            if (abort === 1'b1) n_abort++;
            if (len_err === 1'b1) n_len_err++;
            if (frame_done === 1'b1) n_done++;
            if (abort || len_err || frame_done) begin
                tests_run++;
                if (int'(abort) + int'(len_err) + int'(frame_done) > 1) begin
                    tests_failed++;
                    $display("FAIL exclusive: abort/len_err/done=%b%b%b, required one-hot", abort, len_err, frame_done);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        valid_i = 1'b1;
        sym_i   = n;
        @(posedge CLK);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_sync();
        for (int i = 0; i < 8; i++) send_nib(sync_v[31-4*i -: 4]);
    endtask

    task automatic send_hdr(input logic [15:0] l);
        for (int i = 0; i < 4; i++) send_nib(l[15-4*i -: 4]);
    endtask

    task automatic send_word(input logic [31:0] w, input logic sop, input logic eop);
        exp_t e;
        e.d = w; e.sop = sop; e.eop = eop;
        q.push_back(e);
        for (int i = 0; i < 8; i++) send_nib(w[31-4*i -: 4]);
    endtask

    task automatic test_reset();
        RST = 1'b1; en = 1'b0; valid_i = 1'b0; sym_i = 4'h0;
        idle(3);
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_data_o", data_o, 32'd0);
        check("reset_flags", 32'({sop_o, eop_o, frame_done, abort, len_err, busy}), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        RST = 1'b0;
        en  = 1'b1;
        idle(2);
    endtask

    task automatic test_nominal();
        int d0;
        d0 = n_done;
        send_sync();
        send_hdr(16'h0002);
        send_word(32'h12345678, 1'b1, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0, 1'b1);
        idle(3);
        check("nominal_done_pulses", 32'(n_done - d0), 32'd1);
        check("nominal_frame_cnt", 32'(frame_cnt), 32'd1);
        check("nominal_busy_after", 32'(busy), 32'd0);
        check("nominal_data_hold", data_o, 32'h9ABCDEF0);
    endtask

    task automatic test_hunt();
        int v0;
        v0 = n_valid;
        for (int i = 0; i < 5; i++) send_nib(4'($urandom_range(0, 15)));
        send_nib(4'hA); send_nib(4'h5); send_nib(4'hF);
        send_sync();
        send_hdr(16'h0001);
        send_word(32'hDEADBEEF, 1'b1, 1'b1);
        idle(3);
        check("hunt_word_count", 32'(n_valid - v0), 32'd1);
        check("hunt_frame_cnt", 32'(frame_cnt), 32'd2);
    endtask

    task automatic test_len_err();
        int l0, a0;
        l0 = n_len_err;
        send_sync();
        send_hdr(16'h0000);
        idle(2);
        check("len0_err", 32'(n_len_err - l0), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        send_sync();
        send_hdr(16'h0401);
        idle(2);
        check("len401_err", 32'(n_len_err - l0), 32'd2);
        send_sync();
        send_hdr(16'h0400);
        idle(2);
        check("len400_no_err", 32'(n_len_err - l0), 32'd2);
        check("len400_busy", 32'(busy), 32'd1);
        a0 = n_abort;
        en = 1'b0;
        idle(2);
        en = 1'b1;
        idle(1);
        check("len400_cleanup_abort", 32'(n_abort - a0), 32'd1);
    endtask

    task automatic test_timeout();
        int a0, v0;
        logic [15:0] c0;
        a0 = n_abort; v0 = n_valid;
        send_sync();
        send_hdr(16'h0001);
        send_nib(4'h1); send_nib(4'h2); send_nib(4'h3);
        idle(254);
        check("timeout_not_yet", 32'(n_abort - a0), 32'd0);
        check("timeout_busy_held", 32'(busy), 32'd1);
        idle(1);
        check("timeout_abort_at_255", 32'(abort), 32'd1);
        check("timeout_busy_drop", 32'(busy), 32'd0);
        idle(3);
        check("timeout_abort_once", 32'(n_abort - a0), 32'd1);
        check("timeout_no_word", 32'(n_valid - v0), 32'd0);

        a0 = n_abort; c0 = frame_cnt;
        send_sync();
        send_hdr(16'h0001);
        q.push_back('{d: 32'hCAFE0123, sop: 1'b1, eop: 1'b1});
        send_nib(4'hC); send_nib(4'hA); send_nib(4'hF);
        idle(254);
        send_nib(4'hE); send_nib(4'h0); send_nib(4'h1); send_nib(4'h2); send_nib(4'h3);
        idle(2);
        check("stall254_no_abort", 32'(n_abort - a0), 32'd0);
        check("stall254_complete", 32'(frame_cnt), 32'(c0 + 16'd1));
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [15:0] c0;
        d0 = n_done; c0 = frame_cnt;
        send_sync();
        send_hdr(16'h0001);
        send_word(32'h0BADF00D, 1'b1, 1'b1);
        send_sync();
        send_hdr(16'h0001);
        send_word(32'h55AA33CC, 1'b1, 1'b1);
        idle(2);
        check("b2b_done_pulses", 32'(n_done - d0), 32'd2);
        check("b2b_frame_cnt", 32'(frame_cnt), 32'(c0 + 16'd2));
    endtask

    task automatic test_en_drop();
        int a0;
        a0 = n_abort;
        send_sync();
        send_hdr(16'h0002);
        send_word(32'h01234567, 1'b1, 1'b0);
        send_nib(4'h8); send_nib(4'h9); send_nib(4'hA);
        en = 1'b0;
        idle(1);
        check("en_drop_abort", 32'(abort), 32'd1);
        check("en_drop_busy", 32'(busy), 32'd0);
        idle(3);
        en = 1'b1;
        idle(1);
        check("en_drop_abort_once", 32'(n_abort - a0), 32'd1);
        en = 1'b0;
        idle(3);
        en = 1'b1;
        idle(1);
        check("en_drop_hunt_no_abort", 32'(n_abort - a0), 32'd1);
    endtask

    task automatic test_async_reset();
        send_sync();
        send_hdr(16'h0002);
        send_word(32'h89ABCDEF, 1'b1, 1'b0);
        send_nib(4'h1); send_nib(4'h2); send_nib(4'h3);
        #2;
        RST = 1'b1;
        #1;
        check("rst_data_o", data_o, 32'd0);
        check("rst_flags", 32'({valid_o, sop_o, eop_o, frame_done, abort, len_err, busy}), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        idle(2);
        RST = 1'b0;
        idle(2);
        check("rst_stay_idle", 32'({valid_o, abort, busy}), 32'd0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hunt();
        test_len_err();
        test_timeout();
        test_back_to_back();
        test_en_drop();
        test_async_reset();
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/qam16_rx_frame_ctrl.md
Name: qam16_rx_frame_ctrl

Overview:
Receive-side frame sequencer that sits directly after the QAM16 demapper and consumes its raw 4-bit symbol stream. It hunts for a 32-bit sync word, then reads a 16-bit length header. It then assembles exactly that many 32-bit payload words, marking them with start/end-of-frame flags, and returns to hunt. It aborts on symbol starvation, on an illegal length, or on disable, so downstream packet logic only ever sees well-formed frames.

Parameters:
SYNC_WORD, 32'hA5F03C96, sync pattern, MSB nibble received first
MAX_LEN, 1024, largest legal payload length in 32-bit words
TIMEOUT, 255, idle cycles without valid_i tolerated inside a frame (1..65535)

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  reset, asynchronous, active-high
en  in  1  controller enable
valid_i  in  1  symbol strobe from demapper
sym_i  in  4  demapped QAM16 symbol
valid_o  out  1  payload word strobe, 1-cycle pulse
data_o  out  32  payload word
sop_o  out  1  qualifies valid_o: first word of frame
eop_o  out  1  qualifies valid_o: last word of frame
frame_done  out  1  1-cycle pulse, frame completed
abort  out  1  1-cycle pulse, frame terminated early (timeout or en drop)
len_err  out  1  1-cycle pulse, header length 0 or > MAX_LEN
busy  out  1  high in HEADER or PAYLOAD
frame_cnt  out  16  completed-frame counter, wraps 16'hFFFF -> 0

Behaviour:
- Reset: state HUNT. All outputs are 0 and data_o = 0. The shift register, fill counter, idle counter, length and word counters are cleared.
- States: HUNT, HEADER, PAYLOAD. All transitions are registered.
- Symbol ordering: nibbles are shifted in MSB-first, i.e. {reg[27:0], sym_i}. The first nibble of a word lands in [31:28].
- HUNT:
  - Each valid_i shifts sym_i into the 32-bit hunt register. The fill counter saturates at 8.
  - On a valid_i whose resulting register equals SYNC_WORD, with fill ≥ 8 counting this symbol, the next state is HEADER.
  - Entering HUNT clears the hunt register and fill counter, so no stale symbols from an aborted frame can form a match.
- HEADER:
  - Collects 4 nibbles into len[15:0].
  - On the 4th nibble, if len == 0 or len > MAX_LEN: pulse len_err the next cycle and go to HUNT.
  - Otherwise go to PAYLOAD with word counter = 0 and nibble counter = 0.
- PAYLOAD:
  - Collects 8 nibbles per word.
  - The cycle after the 8th nibble's valid_i: valid_o = 1 and data_o = the assembled word.
  - sop_o = 1 when word counter == 0. eop_o = 1 when word counter == len-1.
  - After the eop word: frame_done pulses in the same cycle as valid_o/eop_o, frame_cnt increments, and the state goes to HUNT.
  - A symbol arriving in the eop cycle belongs to HUNT.
- Latency: one cycle from the final valid_i of a word to valid_o. valid_i may be asserted every cycle; back-to-back frames with zero gap are supported.
- data_o holds its last value when valid_o = 0. sop_o and eop_o are 0 whenever valid_o = 0.
- Timeout:
  - In HEADER/PAYLOAD, the idle counter increments on each cycle without valid_i and clears on valid_i.
  - When it reaches TIMEOUT: pulse abort, go to HUNT, and emit no eop.
  - If valid_i arrives in the same cycle the count would reach TIMEOUT, valid_i wins: the counter clears and the symbol is accepted.
- en:
  - en = 0 forces HUNT synchronously and ignores valid_i.
  - Dropping en while in HEADER/PAYLOAD pulses abort once.
  - en = 0 in HUNT produces no pulse.
- abort, len_err and frame_done are mutually exclusive in any cycle.
- Asynchronous RST mid-frame clears everything immediately. No pulse is emitted and frame_cnt returns to 0.
- busy is a registered decode of the state.

Test Plan:
- Nominal frame: send SYNC_WORD nibbles A,5,F,0,3,C,9,6, then header 0,0,0,2, then 16 payload nibbles 1..8, 9..F,0, valid_i every cycle -> valid_o twice: data_o = 32'h12345678 with sop_o = 1, then 32'h9ABCDEF0 with eop_o = 1 and frame_done = 1. frame_cnt = 1.
- Sync hunt robustness: 5 random nibbles, then a partial sync A,5,F, then the full sync and a 1-word frame (payload 32'hDEADBEEF) -> exactly one valid_o, with sop_o = eop_o = 1 and data_o = 32'hDEADBEEF.
- Length errors: header 0000 -> len_err pulse and return to HUNT. Header 0401h with MAX_LEN = 1024 -> len_err. Header 0400h -> accepted, busy = 1.
- Timeout: stall valid_i for 255 cycles after the 3rd payload nibble -> abort pulses at cycle 255, no valid_o. A stall of 254 cycles followed by valid_i -> no abort and the frame completes.
- Back-to-back: two 1-word frames with zero gap, with the second sync's first nibble in the first frame's eop cycle -> two sop/eop words and frame_cnt = 2.
- Reset/enable mid-frame: drop en during PAYLOAD -> one abort pulse, busy = 0. Assert RST asynchronously mid-PAYLOAD -> all outputs 0 immediately and frame_cnt = 0.
